// File: rtl/vfm_mbox_pkg.sv
// Shared types and constants for the mailbox arbiter: hub FSM encoding and FIFO entry layout.
package vfm_mbox_pkg;

   typedef enum logic [1:0] {
      H_IDLE    = 2'd0,
      H_VALID   = 2'd1,
      H_WAITLOW = 2'd2
   } hub_state_e;

   localparam int unsigned DEFAULT_DW = 14;
   localparam int unsigned SRC_W      = 2;
   // FIFO entry is {src[1:0], data[DW-1:0]}
   localparam int unsigned ENTRY_W    = SRC_W + DEFAULT_DW;

   function automatic int unsigned entry_width(input int unsigned dw);
      return SRC_W + dw;
   endfunction

endpackage

// File: rtl/vfm_mailbox_arbiter_if.sv
// Spoke request bus plus hub delivery bus of the mailbox arbiter; slave is the arbiter side.
interface vfm_mailbox_arbiter_if
   import vfm_mbox_pkg::*;
#(
   parameter int unsigned NREQ       = 3,
   parameter int unsigned DW         = DEFAULT_DW,
   parameter int unsigned FIFO_DEPTH = 4
) ();

   logic [NREQ-1:0]             req_valid;
   logic [NREQ*DW-1:0]          req_data;
   logic [NREQ-1:0]             req_ack;
   logic                        hub_valid;
   logic [DW-1:0]               hub_data;
   logic [1:0]                  hub_src;
   logic                        hub_ack;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        err_timeout;

   modport master (
      output req_valid, req_data, hub_ack,
      input  req_ack, hub_valid, hub_data, hub_src, fifo_count, err_timeout
   );

   modport slave (
      input  req_valid, req_data, hub_ack,
      output req_ack, hub_valid, hub_data, hub_src, fifo_count, err_timeout
   );

endinterface

// File: rtl/vfm_mbox_fifo.sv
// Circular synchronous FIFO; push when full and pop when empty are ignored.
module vfm_mbox_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       wdata,
   output logic [WIDTH-1:0]       rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];
   assign count   = count_q;

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   // Depth is a power of two, so pointers wrap by natural overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: rtl/vfm_mailbox_arbiter.sv
// Round-robin mailbox arbiter: spokes -> FIFO -> four-phase hub handshake.
// Optional hub-ack watchdog enabled by defining VFM_MBOX_TIMEOUT_EN.
module vfm_mailbox_arbiter
   import vfm_mbox_pkg::*;
#(
   parameter int unsigned NREQ           = 3,
   parameter int unsigned DW             = DEFAULT_DW,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic                  Clock_pin,
   input logic                  Resetn_pin,
   vfm_mailbox_arbiter_if.slave bus
);

   localparam int unsigned EW = entry_width(DW);
   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   logic [NREQ-1:0]   req_ack_q, req_ack_d, eligible, grant_oh;
   logic [3:0]        elig4, grant_oh4;
   logic [1:0]        rr_last_q, rr_last_d, grant_idx, cand;
   logic              grant_valid;
   logic [4*DW-1:0]   data4;
   logic [DW-1:0]     grant_data;
   logic [EW-1:0]     fifo_wdata, fifo_rdata;
   logic              fifo_full, fifo_empty, fifo_pop;
   logic [CW-1:0]     fifo_count;

   hub_state_e        state_q, state_d;
   logic              hub_valid_q, hub_valid_d;
   logic [DW-1:0]     hub_data_q, hub_data_d;
   logic [1:0]        hub_src_q, hub_src_d;
   logic              err_q, err_d;
   logic              to_expired;

   // Arbitration: first eligible spoke after the last winner, only when the FIFO has room
   always_comb begin
      eligible    = bus.req_valid & ~req_ack_q;
      elig4       = 4'(eligible);
      grant_valid = 1'b0;
      grant_idx   = rr_last_q;
      cand        = '0;
      if (!fifo_full) begin
         for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = 2'((32'(rr_last_q) + off) % NREQ);
            if (!grant_valid && elig4[cand]) begin
               grant_valid = 1'b1;
               grant_idx   = cand;
            end
         end
      end
      grant_oh4 = grant_valid ? (4'b0001 << grant_idx) : 4'b0000;
      grant_oh  = grant_oh4[NREQ-1:0];
      req_ack_d = (req_ack_q & bus.req_valid) | grant_oh;
      rr_last_d = grant_valid ? grant_idx : rr_last_q;

      data4 = (4*DW)'(bus.req_data);
      unique case (grant_idx)
         2'd0: grant_data = data4[DW-1:0];
         2'd1: grant_data = data4[2*DW-1:DW];
         2'd2: grant_data = data4[3*DW-1:2*DW];
         2'd3: grant_data = data4[4*DW-1:3*DW];
      endcase
      fifo_wdata = {grant_idx, grant_data};
   end

   vfm_mbox_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk   (Clock_pin),
      .rst_n (Resetn_pin),
      .push  (grant_valid),
      .pop   (fifo_pop),
      .wdata (fifo_wdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

`ifdef VFM_MBOX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt_q;

   // Zero outside H_VALID, so the count restarts on every entry
   always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
      if (!Resetn_pin)             to_cnt_q <= '0;
      else if (state_q == H_VALID) to_cnt_q <= to_cnt_q + TW'(1);
      else                         to_cnt_q <= '0;
   end
   assign to_expired = (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign to_expired     = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      hub_valid_d = hub_valid_q;
      hub_data_d  = hub_data_q;
      hub_src_d   = hub_src_q;
      err_d       = err_q;
      fifo_pop    = 1'b0;
      unique case (state_q)
         H_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               hub_data_d  = fifo_rdata[DW-1:0];
               hub_src_d   = fifo_rdata[EW-1:DW];
               hub_valid_d = 1'b1;
               state_d     = H_VALID;
            end
         end
         H_VALID: begin
            if (bus.hub_ack) begin
               hub_valid_d = 1'b0;
               state_d     = H_WAITLOW;
            end else if (to_expired) begin
               hub_valid_d = 1'b0;
               err_d       = 1'b1;
               state_d     = H_IDLE;
            end
         end
         H_WAITLOW: begin
            if (!bus.hub_ack) state_d = H_IDLE;
         end
         default: state_d = H_IDLE;
      endcase
   end

   always_ff @(posedge Clock_pin or negedge Resetn_pin) begin
      if (!Resetn_pin) begin
         req_ack_q   <= '0;
         rr_last_q   <= 2'(NREQ - 1);
         state_q     <= H_IDLE;
         hub_valid_q <= 1'b0;
         hub_data_q  <= '0;
         hub_src_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         req_ack_q   <= req_ack_d;
         rr_last_q   <= rr_last_d;
         state_q     <= state_d;
         hub_valid_q <= hub_valid_d;
         hub_data_q  <= hub_data_d;
         hub_src_q   <= hub_src_d;
         err_q       <= err_d;
      end
   end

   assign bus.req_ack     = req_ack_q;
   assign bus.hub_valid   = hub_valid_q;
   assign bus.hub_data    = hub_data_q;
   assign bus.hub_src     = hub_src_q;
   assign bus.fifo_count  = fifo_count;
   assign bus.err_timeout = err_q;

endmodule

// File: doc/vfm_mailbox_arbiter.md
Name: vfm_mailbox_arbiter

Overview:
- Shares the single hub-core mailbox input (14-bit data plus ack, carried over an In/Out port pair) among up to NREQ spoke cores in a multicore build.
- Spokes post words with a four-phase valid/ack handshake. Words are arbitrated round-robin into an output FIFO.
- The FIFO drains to the hub core over a second four-phase handshake, tagged with the source index.
- Sits in the top level between the spoke cores' Out ports and the hub core's In ports, replacing point-to-point ack/data wiring.

Parameters:
- NREQ, 3, number of spoke requesters (1..4).
- DW, 14, mailbox data width in bits.
- FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.
- TIMEOUT_CYCLES, 1024, hub-ack watchdog limit; used only with the optional feature.

Ports:
- Clock_pin  in  1  system clock; all logic on the rising edge.
- Resetn_pin  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-spoke request level; data must be held stable while high.
- req_data  in  NREQ*DW  flattened spoke data; spoke i occupies bits [i*DW +: DW].
- req_ack  out  NREQ  per-spoke acknowledge level.
- hub_valid  out  1  word available to the hub.
- hub_data  out  DW  word to the hub.
- hub_src  out  2  index of the spoke that posted hub_data.
- hub_ack  in  1  hub acknowledge level.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- err_timeout  out  1  sticky watchdog error; always 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous assert, synchronous release): req_ack=0, hub_valid=0, hub_data=0, hub_src=0, fifo_count=0, err_timeout=0, rr_last=NREQ-1, hub FSM=H_IDLE. All registered outputs.
- Eligible requester i: req_valid[i]=1 and req_ack[i]=0.
- Capture, at most one per cycle:
  - Only if the FIFO is not full at the start of the cycle.
  - Grant goes to the first eligible index scanning rr_last+1, rr_last+2, ... modulo NREQ.
  - Push {i, req_data[i]}, set req_ack[i]=1 and rr_last=i.
  - Latency: req_valid sampled high at edge k gives req_ack high after edge k, when the FIFO has room and i wins arbitration.
- Spoke release: req_ack[i] clears on the first edge where req_valid[i]=0 while req_ack[i]=1. No new capture from i until its ack is low.
- Full FIFO: no capture, no ack. A pop in the same cycle does not enable a push; push resumes on the next cycle.
- Hub FSM:
  - H_IDLE: if FIFO is non-empty, load head into hub_data/hub_src, pop, hub_valid=1, go to H_VALID.
  - H_VALID: on hub_ack=1, hub_valid=0, go to H_WAITLOW. hub_data/hub_src hold their value.
  - H_WAITLOW: on hub_ack=0, go to H_IDLE.
- Pop happens on the H_IDLE→H_VALID edge. A push and a pop in the same cycle leave fifo_count unchanged.
- Minimum hub cadence: one word per 3 cycles.
- FIFO: circular, pointers wrap modulo FIFO_DEPTH, count saturates exactly at FIFO_DEPTH.
- req_valid dropping before ack (protocol violation): the request is simply not captured.
- hub_ack high while in H_IDLE is ignored.
- Reset mid-operation discards FIFO contents and any in-flight hub word. A spoke still holding req_valid=1 is re-captured after reset; duplicate delivery is accepted, and software de-dups by sequence number in the data.

Optional Feature:
- Macro VFM_MBOX_TIMEOUT_EN.
- Defined:
  - A counter runs while in H_VALID.
  - If it reaches TIMEOUT_CYCLES with hub_ack still 0: hub_valid=0, word dropped, err_timeout=1 (sticky until reset), go to H_IDLE.
  - Counter clears on entry to H_VALID.
- Undefined: no counter, H_VALID waits indefinitely, err_timeout tied 0.

Decomposition:
- Package vfm_mbox_pkg holds:
  - hub FSM state encoding (H_IDLE, H_VALID, H_WAITLOW);
  - default DW=14;
  - the FIFO entry layout {src[1:0], data[DW-1:0]} as a packed width constant.
- Sub-module vfm_mbox_fifo: synchronous FIFO with push/pop/full/empty/count; arbiter and hub FSM stay in the top module.

Test Plan:
- Single word: spoke1 raises valid with 0x1ABC → req_ack[1]=1 next cycle; hub_valid=1, hub_data=0x1ABC, hub_src=1; hub_ack handshake completes; fifo_count returns to 0.
- Round-robin: spokes 0, 1, 2 all valid in the same cycle from reset → acks in order 0, 1, 2 on consecutive cycles. After spoke0 re-requests with 1 and 2 also pending, order is 1, 2, 0.
- Full: FIFO_DEPTH=4 with hub_ack held 0 → 4 words accepted (the first leaves into hub_data, so 5 acks total), fifo_count=4; the next requester stays un-acked until the hub completes a handshake.
- Simultaneous push/pop: steady hub acking while spoke2 streams → fifo_count never exceeds 1, no words lost, order preserved.
- Reset mid-operation: Resetn_pin low with 3 words queued and hub_valid=1 → all outputs at reset values immediately; the held spoke is re-acked after release.
- Timeout (VFM_MBOX_TIMEOUT_EN, TIMEOUT_CYCLES=16): hub never acks → hub_valid drops after 16 cycles, err_timeout=1 and stays set; the next word is delivered normally.
